// File: rtl/data_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : data_mem_pkg                                           |
// | Description : Shared types and constants for the data-memory         |
// |               arbiter: default widths, port indices, command         |
// |               record and arbiter state encoding.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package data_mem_pkg;

    localparam int DATA_AW = 8;
    localparam int DATA_DW = 16;

    // Requester indices; also the value of the read-return owner tag
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // One memory command as presented to the macro
    typedef struct packed {
        logic               we;
        logic [DATA_AW-1:0] addr;
        logic [DATA_DW-1:0] wdata;
    } mem_cmd_t;

    // ST_ISSUE means a command sits on the mem_* bus this cycle
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter2                                            |
// | Description : Two-input round-robin grant. A sole requester always   |
// |               wins; on a tie the port not served last wins. The      |
// |               last-served pointer moves only when a grant is given.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter2
    import data_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Pick the winner for this cycle and the pointer value it implies
    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt = (last_q == PORT_DBG) ? 2'b01 : 2'b10;
        end
        if (gnt[1]) begin
            last_d = PORT_DBG;
        end else if (gnt[0]) begin
            last_d = PORT_CPU;
        end
    end

    // Pointer resets to the debug port so the CPU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : data_mem_arbiter                                       |
// | Description : Shares a single-port synchronous data memory between   |
// |               the CPU (port 0) and the debug/loader path (port 1).   |
// |               One registered command per cycle; read data returns    |
// |               to the owning port two cycles after its request.       |
// |               Define DBG_PRIORITY_EN for fixed debug-first priority; |
// |               otherwise two-way round-robin is used.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int AW = DATA_AW,
    parameter int DW = DATA_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0] win;

`ifdef DBG_PRIORITY_EN
    // Fixed priority: debug always beats the CPU
    always_comb begin
        win = 2'b00;
        if (dbg_req) begin
            win = 2'b10;
        end else if (cpu_req) begin
            win = 2'b01;
        end
    end
`else
    logic [1:0] req_vec;
    assign req_vec = {dbg_req, cpu_req};

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst),
        .req   (req_vec),
        .gnt   (win)
    );
`endif

    arb_state_t    state_q,      state_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    logic          cpu_gnt_q,    cpu_gnt_d;
    logic          dbg_gnt_q,    dbg_gnt_d;
    logic          rd_q,         rd_d;
    logic          tag_q,        tag_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] cpu_hold_q,   cpu_hold_d;
    logic [DW-1:0] dbg_hold_q,   dbg_hold_d;

    // Next command from the winner, plus read-return bookkeeping for the
    // command currently on the bus (its data appears on mem_rdata next cycle)
    always_comb begin
        state_d      = ST_IDLE;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_gnt_d    = win[0];
        dbg_gnt_d    = win[1];
        rd_d         = 1'b0;
        tag_d        = tag_q;
        if (win[1]) begin
            state_d     = ST_ISSUE;
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            rd_d        = ~dbg_we;
            tag_d       = PORT_DBG;
        end else if (win[0]) begin
            state_d     = ST_ISSUE;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            rd_d        = ~cpu_we;
            tag_d       = PORT_CPU;
        end
        cpu_rvalid_d = rd_q & (tag_q == PORT_CPU);
        dbg_rvalid_d = rd_q & (tag_q == PORT_DBG);
        cpu_hold_d   = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
        dbg_hold_d   = dbg_rvalid_q ? mem_rdata : dbg_hold_q;
    end

    // Command/handshake state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            rd_q         <= 1'b0;
            tag_q        <= PORT_CPU;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_hold_q   <= '0;
            dbg_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            rd_q         <= rd_d;
            tag_q        <= tag_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_hold_q   <= cpu_hold_d;
            dbg_hold_q   <= dbg_hold_d;
        end
    end

    assign mem_en     = (state_q == ST_ISSUE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    // Returned data is forwarded in its valid cycle, then held afterwards
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
    assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : dbg_hold_q;
    assign cpu_stall  = cpu_req & ~cpu_gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_data_mem_arbiter                                    |
// | Description : Self-checking bench for data_mem_arbiter with a        |
// |               behavioural memory and a cycle-level reference model.  |
// |               Follows DBG_PRIORITY_EN when it is defined.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_data_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
`ifdef DBG_PRIORITY_EN
    localparam bit DBG_FIRST = 1'b1;
`else
    localparam bit DBG_FIRST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return DW'(i * 16'h0101) ^ 16'h5A5A;
    endfunction

    // Synchronous single-port memory macro
    logic [DW-1:0] mem_array [0:255];
    logic          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem_array[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            m_last;
    logic          e_cpu_gnt, e_dbg_gnt, e_en, e_we, e_rd;
    int            e_own;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdval;
    logic          e_cpu_rv, e_dbg_rv;
    logic [DW-1:0] e_cpu_rdata, e_dbg_rdata;

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        e_cpu_gnt = 0; e_dbg_gnt = 0; e_en = 0; e_we = 0; e_rd = 0; e_own = 0;
        e_addr = '0; e_wdata = '0; e_rdval = '0;
        e_cpu_rv = 0; e_dbg_rv = 0; e_cpu_rdata = '0; e_dbg_rdata = '0;
    endtask

    // Advance the model by one rising edge using the inputs now applied
    task automatic model_edge();
        int winner;
        if (!rst) begin
            model_reset();
            return;
        end
        e_cpu_rv = e_rd && (e_own == 0);
        e_dbg_rv = e_rd && (e_own == 1);
        if (e_cpu_rv) e_cpu_rdata = e_rdval;
        if (e_dbg_rv) e_dbg_rdata = e_rdval;
        winner = -1;
        if (cpu_req && dbg_req) winner = DBG_FIRST ? 1 : ((m_last == 1) ? 0 : 1);
        else if (cpu_req)       winner = 0;
        else if (dbg_req)       winner = 1;
        e_cpu_gnt = (winner == 0);
        e_dbg_gnt = (winner == 1);
        if (winner >= 0) begin
            m_last  = winner;
            e_en    = 1;
            e_we    = (winner == 1) ? dbg_we    : cpu_we;
            e_addr  = (winner == 1) ? dbg_addr  : cpu_addr;
            e_wdata = (winner == 1) ? dbg_wdata : cpu_wdata;
            e_own   = winner;
            e_rd    = !e_we;
            if (e_we) ref_mem[e_addr] = e_wdata;
            else      e_rdval = ref_mem[e_addr];
        end else begin
            e_en = 0;
            e_we = 0;
            e_rd = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("cpu_gnt",    cpu_gnt,    e_cpu_gnt);
        check_eq("dbg_gnt",    dbg_gnt,    e_dbg_gnt);
        check_eq("cpu_stall",  cpu_stall,  cpu_req & ~e_cpu_gnt);
        check_eq("mem_en",     mem_en,     e_en);
        check_eq("mem_we",     mem_we,     e_we);
        check_eq("mem_addr",   mem_addr,   e_addr);
        check_eq("mem_wdata",  mem_wdata,  e_wdata);
        check_eq("cpu_rvalid", cpu_rvalid, e_cpu_rv);
        check_eq("dbg_rvalid", dbg_rvalid, e_dbg_rv);
        check_eq("cpu_rdata",  cpu_rdata,  e_cpu_rdata);
        check_eq("dbg_rdata",  dbg_rdata,  e_dbg_rdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(logic cr, logic cw, logic [AW-1:0] ca, logic [DW-1:0] cd,
                         logic dr, logic dw, logic [AW-1:0] da, logic [DW-1:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic idle(int n);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        idle(2);

        // Simultaneous reads: first tie goes to the CPU (debug under priority)
        drive(1, 0, 8'h05, '0, 1, 0, 8'h06, '0);
        cycle();
        idle(3);

        // CPU write then read back
        drive(1, 1, 8'h10, 16'hBEEF, 0, 0, '0, '0);
        cycle();
        drive(1, 0, 8'h10, '0, 0, 0, '0, '0);
        cycle();
        idle(3);

        // Both ports requesting for six cycles
        drive(1, 0, 8'h20, '0, 1, 0, 8'h21, '0);
        for (int i = 0; i < 6; i++) cycle();
        idle(3);

        // Boundary addresses, back-to-back debug reads
        drive(0, 0, '0, '0, 1, 1, 8'hFF, 16'h1234);
        cycle();
        drive(0, 0, '0, '0, 1, 0, 8'h00, '0);
        cycle();
        drive(0, 0, '0, '0, 1, 0, 8'hFF, '0);
        cycle();
        idle(3);

        // Reset asserted one cycle into an in-flight CPU read
        drive(1, 0, 8'h10, '0, 0, 0, '0, '0);
        cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        check_outputs();
        idle(2);
        rst = 1'b1;
        idle(1);
        drive(1, 0, 8'h10, '0, 0, 0, '0, '0);
        cycle();
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ca, da;
            ca = 8'($urandom_range(0, 255));
            da = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ca = 8'h00;
            if ($urandom_range(0, 7) == 0) da = 8'hFF;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ca, 16'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, da, 16'($urandom));
            cycle();
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous 16-bit data memory between two requesters.
- Port 0 is the CPU load/store path. Port 1 is the debug/loader path, which preloads and inspects memory during bring-up.
- Sits between system_cpu_master's memory interface and the data memory macro.
- Issues at most one memory command per cycle and routes read data back to the owning requester with a valid strobe.

Parameters:
- AW, 8, address width in words.
- DW, 16, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; low = reset.
- cpu_req  input  1  CPU access request; held until cpu_gnt.
- cpu_we  input  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  input  AW  CPU word address.
- cpu_wdata  input  DW  CPU write data.
- cpu_gnt  output  1  one-cycle pulse: CPU command issued this cycle.
- cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  output  DW  read data to CPU.
- cpu_stall  output  1  cpu_req & ~cpu_gnt (combinational); freezes PC.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same as the cpu_* ports, for the debug port.
- mem_en  output  1  memory command valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid one cycle after a read command.

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0; mem_addr/mem_wdata 0.
  - last-served pointer = port 1, so the CPU wins the first tie.
  - pipeline tag cleared.
- State machine, per rising edge:
  - IDLE: no req, hold.
  - ISSUE: ≥1 req; choose winner, register command onto mem_* and pulse the winner's gnt in the next cycle.
- Latency:
  - req sampled high at edge N → mem_en and gnt high during cycle N+1.
  - Read data is captured from mem_rdata → *_rdata/*_rvalid high during cycle N+2.
  - Writes produce no rvalid.
- Throughput:
  - One command per cycle, fully pipelined.
  - A requester may keep req high after gnt to issue back-to-back accesses; each gnt consumes one command.
- Arbitration (default): two-way round-robin.
  - Sole requester always wins.
  - Simultaneous requests → grant the port not served last.
  - The pointer updates only on a grant.
- Handshake:
  - Requester inputs must be stable from req rise until gnt.
  - Dropping req before gnt is legal; the request is withdrawn with no access issued.
- Read return:
  - A one-bit owner tag plus a read flag are registered with the command; rvalid goes only to the tag owner.
  - The non-owner's rdata holds its last value.
- Simultaneous events: a new grant in cycle N+1 and rvalid for the previous read in the same cycle are independent and both occur.
- Reset mid-operation: an in-flight read is discarded (no rvalid) and mem_en drops immediately.
- Boundaries:
  - Addresses 0 and 2^AW-1 pass unmodified; no wrap logic.
  - DW is passed through; no width conversion.

Optional Feature:
- DBG_PRIORITY_EN defined: fixed priority; dbg_req always beats cpu_req (CPU stalls while debug loads), and the pointer is unused.
- Undefined: round-robin as above.

Decomposition:
- Package data_mem_pkg holds:
  - AW/DW defaults;
  - port index constants PORT_CPU=0, PORT_DBG=1;
  - command struct {we, addr, wdata};
  - FSM state encoding.
- Natural sub-module: rr_arbiter2, the 2-input round-robin grant with pointer; it is bypassed under DBG_PRIORITY_EN.

Test Plan:
- Reset release, no requests → all outputs 0; first simultaneous req grants the CPU.
- CPU write addr 0x10 data 0xBEEF, then CPU read 0x10:
  - gnt 1 cycle after req;
  - cpu_rvalid with cpu_rdata=0xBEEF 2 cycles after read req;
  - dbg_rvalid stays 0.
- Both ports hold req for 6 cycles → grants alternate CPU, DBG, CPU, DBG, CPU, DBG; cpu_stall high on DBG cycles (without DBG_PRIORITY_EN).
- With DBG_PRIORITY_EN, both req for 4 cycles → dbg_gnt 4×, cpu_gnt 0, cpu_stall high throughout.
- Back-to-back DBG reads of 0x00 and 0xFF → two consecutive dbg_rvalid pulses with the correct data in order.
- Assert rst low one cycle after a CPU read grant → no cpu_rvalid; all outputs 0 asynchronously; normal operation after release.
